// File: rtl/soc_pmc_pkg.sv
// Shared types and default widths for the PMC gate/strobe timing generator.
package soc_pmc_pkg;

   localparam int PMC_CNT_W = 16;
   localparam int PMC_NUM_W = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FINISH = 2'd2
   } soc_pmc_state_t;

   typedef struct packed {
      logic [PMC_CNT_W-1:0] gate_len;
      logic [PMC_CNT_W-1:0] strobe_delay;
      logic [PMC_CNT_W-1:0] strobe_width;
      logic [PMC_CNT_W-1:0] strobe_period;
      logic [PMC_NUM_W-1:0] strobe_count;
   } soc_pmc_cfg_t;

endpackage

// File: rtl/soc_pmc_bus.sv
// Gate/strobe bus from the timing generator to the pixel matrix.
interface soc_pmc_bus;
   logic gate;
   logic strobe;

   modport slave  (output gate, output strobe);
   modport master (input  gate, input  strobe);
endinterface

// File: rtl/soc_pmc_strobe_gen.sv
// Strobe train sequencer: delay, in-period phase and pulse-index counters.
// strobe_next_o describes the cycle that will be registered at the next edge.
module soc_pmc_strobe_gen
   import soc_pmc_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable_i,
   input  logic                 clear_i,
   input  logic [PMC_CNT_W-1:0] strobe_delay_i,
   input  logic [PMC_CNT_W-1:0] strobe_width_i,
   input  logic [PMC_CNT_W-1:0] strobe_period_i,
   input  logic [PMC_NUM_W-1:0] strobe_count_i,
   output logic                 strobe_next_o
);

   logic [PMC_CNT_W-1:0] dly_q, dly_d;
   logic [PMC_CNT_W-1:0] phase_q, phase_d;
   logic [PMC_NUM_W-1:0] pulse_q, pulse_d;
   logic [PMC_NUM_W-1:0] eff_count;
   logic                 in_delay;
   logic                 last_pulse;
   logic                 wrap;

   always_comb begin
      eff_count = strobe_count_i;
      if (strobe_period_i == '0 && strobe_count_i != '0) begin
         eff_count = PMC_NUM_W'(1);
      end
      in_delay   = (dly_q != strobe_delay_i);
      last_pulse = (pulse_q == eff_count - PMC_NUM_W'(1));
      // The last pulse never wraps, so it runs its full width even when period < width.
      wrap = !last_pulse && (strobe_period_i != '0)
             && (phase_q == strobe_period_i - PMC_CNT_W'(1));
      strobe_next_o = !in_delay && (pulse_q < eff_count) && (phase_q < strobe_width_i);

      dly_d   = dly_q;
      phase_d = phase_q;
      pulse_d = pulse_q;
      if (clear_i) begin
         dly_d   = '0;
         phase_d = '0;
         pulse_d = '0;
      end else if (enable_i) begin
         if (in_delay) begin
            dly_d = dly_q + PMC_CNT_W'(1);
         end else if (wrap) begin
            phase_d = '0;
            pulse_d = pulse_q + PMC_NUM_W'(1);
         end else if (phase_q != '1) begin
            phase_d = phase_q + PMC_CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dly_q   <= '0;
         phase_q <= '0;
         pulse_q <= '0;
      end else begin
         dly_q   <= dly_d;
         phase_q <= phase_d;
         pulse_q <= pulse_d;
      end
   end

endmodule

// File: rtl/soc_pmc_gate_gen.sv
// PMC timing generator: one start opens a gate window of gate_len cycles with a strobe train inside.
// gate/strobe/done are registered one cycle after the decision; abort returns to IDLE on the next edge.
module soc_pmc_gate_gen
   import soc_pmc_pkg::*;
#(
   parameter int CNT_WIDTH = PMC_CNT_W,
   parameter int NUM_WIDTH = PMC_NUM_W
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 abort,
   input  logic [CNT_WIDTH-1:0] gate_len,
   input  logic [CNT_WIDTH-1:0] strobe_delay,
   input  logic [CNT_WIDTH-1:0] strobe_width,
   input  logic [CNT_WIDTH-1:0] strobe_period,
   input  logic [NUM_WIDTH-1:0] strobe_count,
   output logic                 busy,
   output logic                 done,
   soc_pmc_bus.slave            pmc_bus
);

   soc_pmc_state_t       state_q, state_d;
   soc_pmc_cfg_t         cfg_q, cfg_d;
   logic [PMC_CNT_W-1:0] gate_cnt_q, gate_cnt_d;
   logic                 gate_q, strobe_q, done_q;
   logic                 run_next;
   logic                 strobe_next;

   always_comb begin
      state_d    = state_q;
      cfg_d      = cfg_q;
      gate_cnt_d = gate_cnt_q;
      unique case (state_q)
         IDLE: begin
            if (start && !abort) begin
               cfg_d.gate_len      = PMC_CNT_W'(gate_len);
               cfg_d.strobe_delay  = PMC_CNT_W'(strobe_delay);
               cfg_d.strobe_width  = PMC_CNT_W'(strobe_width);
               cfg_d.strobe_period = PMC_CNT_W'(strobe_period);
               cfg_d.strobe_count  = PMC_NUM_W'(strobe_count);
               gate_cnt_d          = PMC_CNT_W'(1);
               state_d             = (gate_len == '0) ? FINISH : RUN;
            end
         end
         RUN: begin
            if (abort) begin
               state_d    = IDLE;
               gate_cnt_d = '0;
            end else if (gate_cnt_q == cfg_q.gate_len) begin
               state_d    = FINISH;
               gate_cnt_d = '0;
            end else if (gate_cnt_q != '1) begin
               gate_cnt_d = gate_cnt_q + PMC_CNT_W'(1);
            end
         end
         FINISH: begin
            state_d    = IDLE;
            gate_cnt_d = '0;
         end
         default: begin
            state_d    = IDLE;
            gate_cnt_d = '0;
         end
      endcase
      run_next = (state_d == RUN);
   end

   // Fed with cfg_d so the start cycle already sees the config being latched.
   soc_pmc_strobe_gen u_strobe_gen (
      .clk             (clk),
      .rst_n           (rst_n),
      .enable_i        (run_next),
      .clear_i         (!run_next),
      .strobe_delay_i  (cfg_d.strobe_delay),
      .strobe_width_i  (cfg_d.strobe_width),
      .strobe_period_i (cfg_d.strobe_period),
      .strobe_count_i  (cfg_d.strobe_count),
      .strobe_next_o   (strobe_next)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cfg_q      <= '0;
         gate_cnt_q <= '0;
         gate_q     <= 1'b0;
         strobe_q   <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cfg_q      <= cfg_d;
         gate_cnt_q <= gate_cnt_d;
         gate_q     <= run_next;
         strobe_q   <= strobe_next && run_next;
         done_q     <= (state_d == FINISH);
      end
   end

   assign busy           = (state_q != IDLE);
   assign done           = done_q;
   assign pmc_bus.gate   = gate_q;
   assign pmc_bus.strobe = strobe_q;

endmodule

// File: doc/soc_pmc_gate_gen.md
# soc_pmc_gate_gen

Timing generator for the pixel matrix controller (PMC). On a start pulse it opens an acquisition gate window of programmable length and emits a programmable train of strobe pulses inside that window. It drives gate and strobe onto a `soc_pmc_bus` through its `slave` modport. It is configured and started by the CPU-side PMC register block, and reports busy and done back to it.

## Interface
- `CNT_WIDTH`, 16: width of the gate-length, delay, width and period counters.
- `NUM_WIDTH`, 8: width of the strobe-count field.

- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  single-cycle request to begin a sequence
- `abort`  in  1  single-cycle request to terminate the running sequence
- `gate_len`  in  CNT_WIDTH  gate high duration, in cycles
- `strobe_delay`  in  CNT_WIDTH  cycles from gate rise to the first strobe rise
- `strobe_width`  in  CNT_WIDTH  strobe high duration, in cycles
- `strobe_period`  in  CNT_WIDTH  cycles between successive strobe rises
- `strobe_count`  in  NUM_WIDTH  number of strobe pulses
- `busy`  out  1  sequence in progress
- `done`  out  1  single-cycle pulse on normal completion
- `pmc_bus`  `soc_pmc_bus.slave`  —  drives `gate` and `strobe` (both registered)

## Operation
- FSM states: IDLE, RUN, FINISH.
- Reset: state IDLE; `gate`, `strobe`, `busy`, `done` all 0; all counters 0.
- IDLE with `start` high:
  - Latch all five config inputs into the internal config register.
  - If latched `gate_len` = 0, go to FINISH with no gate.
  - Otherwise go to RUN.
- Config inputs are ignored outside the start cycle.
- RUN:
  - `gate` is high.
  - The gate counter counts `gate_len` cycles, then the FSM goes to FINISH.
- FINISH: `done` is high for one cycle, then the FSM goes to IDLE.
- `busy` = (state != IDLE).
- `start` while busy is ignored; no queuing.
- Strobe train, with k = 0 … strobe_count−1:
  - Pulse k rises `strobe_delay` + k·`strobe_period` cycles after gate rise.
  - Each pulse stays high for `strobe_width` cycles.
  - `strobe` is always ANDed with the gate condition, so pulses are truncated at gate fall and pulses falling beyond the gate are dropped.
- Degenerate strobe settings:
  - `strobe_count` = 0 or `strobe_width` = 0: no strobes.
  - `strobe_period` = 0: count is clamped to 1.
  - `strobe_period` ≤ `strobe_width`: adjacent pulses merge, and `strobe` stays high continuously until the last pulse ends.
- `abort` in RUN or FINISH:
  - Next cycle: `gate` = 0, `strobe` = 0, state IDLE, `done` = 0.
  - `abort` takes priority over normal completion in the same cycle.
- `abort` in IDLE has no effect. `abort` and `start` together in IDLE: `abort` wins and the sequence does not start.
- Counters saturate at their terminal values and never wrap. All arithmetic is unsigned at CNT_WIDTH.

## Timing
- `start` sampled at rising edge t:
  - `gate` and `busy` are high from t+1 through t+`gate_len`.
  - `gate` is low at t+`gate_len`+1, and `done` is high in that same cycle.
  - `busy` falls at t+`gate_len`+2.
- Strobe pulse k is high in cycles t+1+`strobe_delay`+k·`strobe_period` through +`strobe_width`−1, clipped to the gate window.
- `gate_len` = 0: `busy` high at t+1, `done` high at t+1, idle at t+2.
- Back-to-back operation: the earliest accepted restart is the cycle in which `busy` is low (t+`gate_len`+2).
- Reset asserted mid-sequence: all outputs go to 0 asynchronously; no `done`.

## Structure
- Package `soc_pmc_pkg` holds:
  - `soc_pmc_state_t` enum (IDLE, RUN, FINISH).
  - `soc_pmc_cfg_t` packed struct (gate_len, strobe_delay, strobe_width, strobe_period, strobe_count).
  - Default width localparams.
- Sub-module `soc_pmc_strobe_gen` holds:
  - Delay, phase and remaining-pulse counters.
  - Inputs: enable (= RUN), the latched config, and a clear signal.
  - Output: combinational `strobe_next`, which the top level ANDs with gate and registers.

## Test plan
- gate_len=10, count=0, start at t → `gate` high t+1..t+10; `done` only at t+11; `busy` low at t+12; `strobe` never high.
- gate_len=20, delay=2, width=3, period=5, count=3 → `strobe` high t+3..5, t+8..10, t+13..15; exactly 3 rising edges.
- gate_len=8, delay=2, width=4, period=4, count=4 → strobes merge into t+3..t+8; `strobe` falls with `gate`; pulses beyond the gate are dropped.
- gate_len=0 → `busy` and `done` both high at t+1 only; `gate` never high.
- gate_len=100 with `abort` at t+30 → `gate`/`strobe` low at t+31, `busy` low at t+31, no `done`. A second `start` during RUN changes nothing, and new config values applied mid-run have no effect.
- `rst_n` pulsed low at t+5 of a gate_len=50 run → all outputs 0 immediately. A `start` after release gives a normal sequence.
